// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared video geometry constants and sprite motion mode enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 11;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        MANUAL = 2'd1,
        PAUSED = 2'd2
    } motion_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchronizer for a raw button plus a registered
//                rising-edge press pulse (3 clk from pin to pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign o_level = r_sync2;
    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl
//  Description : Per-frame sprite position update (bounce / manual / pause),
//                applied once at the start of vertical blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl #(
    parameter int H_ACTIVE  = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = video_pkg::V_ACTIVE,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 16,
    parameter int X_INIT    = 304,
    parameter int Y_INIT    = 232,
    parameter int MAX_SPEED = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [video_pkg::COORD_W-1:0] pix_x,
    input  logic [video_pkg::COORD_W-1:0] pix_y,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          btn_mode,
    input  logic                          btn_pause,
    input  logic                          btn_speed,
    output logic [video_pkg::COORD_W-1:0] POSX,
    output logic [video_pkg::COORD_W-1:0] pos_y,
    output logic                          frame_tick,
    output logic                          hit_wall
);

    import video_pkg::COORD_W;
    import video_pkg::motion_state_t;
    import video_pkg::BOUNCE;
    import video_pkg::MANUAL;
    import video_pkg::PAUSED;

    localparam logic signed [COORD_W:0] c_XMAX      = (COORD_W+1)'(H_ACTIVE - SPRITE_W);
    localparam logic signed [COORD_W:0] c_YMAX      = (COORD_W+1)'(V_ACTIVE - SPRITE_H);
    localparam logic [2:0]              c_MAX_SPEED = 3'(MAX_SPEED);

    // Button order: {speed, pause, mode, right, left}
    logic [4:0] w_btn_raw;
    logic [4:0] w_level;
    logic [4:0] w_pulse;
    logic [4:0] w_unused_btn;

    assign w_btn_raw = {btn_speed, btn_pause, btn_mode, btn_right, btn_left};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_sync_edge u_btn (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (w_btn_raw[i]),
            .o_level (w_level[i]),
            .o_pulse (w_pulse[i])
        );
    end

    assign w_unused_btn = {w_level[4:2], w_pulse[1:0]};

    logic w_left, w_right, w_mode_p, w_pause_p, w_speed_p;
    assign w_left    = w_level[0];
    assign w_right   = w_level[1];
    assign w_mode_p  = w_pulse[2];
    assign w_pause_p = w_pulse[3];
    assign w_speed_p = w_pulse[4];

    logic                   r_vb, r_vb_q, w_vb, w_tick;
    motion_state_t          r_state, r_resume, w_state_nxt, w_resume_nxt;
    logic [2:0]             r_speed;
    logic                   r_vx_neg, r_vy_neg, w_vx_neg_nxt, w_vy_neg_nxt;
    logic [COORD_W-1:0]     r_posx, r_posy, w_posx_nxt, w_posy_nxt;
    logic signed [COORD_W:0] w_x, w_y, w_step, w_nx, w_ny;
    logic                   w_clamp;

    assign w_vb   = (pix_x == '0) && (pix_y == COORD_W'(V_ACTIVE));
    assign w_tick = r_vb & ~r_vb_q;

    // Mode press is resolved before pause so a joint press pauses into the new mode.
    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;
        if (w_mode_p) begin
            case (w_state_nxt)
                BOUNCE:  w_state_nxt  = MANUAL;
                MANUAL:  w_state_nxt  = BOUNCE;
                default: w_resume_nxt = (r_resume == BOUNCE) ? MANUAL : BOUNCE;
            endcase
        end
        if (w_pause_p) begin
            if (w_state_nxt == PAUSED) begin
                w_state_nxt = w_resume_nxt;
            end else begin
                w_resume_nxt = w_state_nxt;
                w_state_nxt  = PAUSED;
            end
        end
    end

    assign w_x    = {1'b0, r_posx};
    assign w_y    = {1'b0, r_posy};
    assign w_step = {{(COORD_W-2){1'b0}}, r_speed};

    always_comb begin
        w_posx_nxt   = r_posx;
        w_posy_nxt   = r_posy;
        w_vx_neg_nxt = r_vx_neg;
        w_vy_neg_nxt = r_vy_neg;
        w_clamp      = 1'b0;
        w_nx         = r_vx_neg ? (w_x - w_step) : (w_x + w_step);
        w_ny         = r_vy_neg ? (w_y - w_step) : (w_y + w_step);
        case (r_state)
            BOUNCE: begin
                if (w_nx[COORD_W]) begin
                    w_posx_nxt   = '0;
                    w_vx_neg_nxt = 1'b0;
                    w_clamp      = 1'b1;
                end else if (w_nx > c_XMAX) begin
                    w_posx_nxt   = c_XMAX[COORD_W-1:0];
                    w_vx_neg_nxt = 1'b1;
                    w_clamp      = 1'b1;
                end else begin
                    w_posx_nxt   = w_nx[COORD_W-1:0];
                end
                if (w_ny[COORD_W]) begin
                    w_posy_nxt   = '0;
                    w_vy_neg_nxt = 1'b0;
                    w_clamp      = 1'b1;
                end else if (w_ny > c_YMAX) begin
                    w_posy_nxt   = c_YMAX[COORD_W-1:0];
                    w_vy_neg_nxt = 1'b1;
                    w_clamp      = 1'b1;
                end else begin
                    w_posy_nxt   = w_ny[COORD_W-1:0];
                end
            end
            MANUAL: begin
                if (w_left && !w_right) begin
                    w_nx = w_x - w_step;
                    if (w_nx[COORD_W]) begin
                        w_posx_nxt = '0;
                        w_clamp    = 1'b1;
                    end else begin
                        w_posx_nxt = w_nx[COORD_W-1:0];
                    end
                end else if (w_right && !w_left) begin
                    w_nx = w_x + w_step;
                    if (w_nx > c_XMAX) begin
                        w_posx_nxt = c_XMAX[COORD_W-1:0];
                        w_clamp    = 1'b1;
                    end else begin
                        w_posx_nxt = w_nx[COORD_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vb     <= 1'b0;
            r_vb_q   <= 1'b0;
            r_state  <= BOUNCE;
            r_resume <= BOUNCE;
            r_speed  <= 3'd1;
            r_vx_neg <= 1'b0;
            r_vy_neg <= 1'b0;
            r_posx   <= COORD_W'(X_INIT);
            r_posy   <= COORD_W'(Y_INIT);
        end else begin
            r_vb     <= w_vb;
            r_vb_q   <= r_vb;
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            if (w_speed_p) begin
                r_speed <= (r_speed == c_MAX_SPEED) ? 3'd1 : r_speed + 3'd1;
            end
            if (w_tick) begin
                r_posx   <= w_posx_nxt;
                r_posy   <= w_posy_nxt;
                r_vx_neg <= w_vx_neg_nxt;
                r_vy_neg <= w_vy_neg_nxt;
            end
        end
    end

    assign POSX       = r_posx;
    assign pos_y      = r_posy;
    assign frame_tick = w_tick;
    assign hit_wall   = w_tick & w_clamp;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_motion_ctrl
//  Description : Self-checking bench for sprite_motion_ctrl against a
//                frame-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_ctrl;

    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pix_x, pix_y;
    logic        btn_left, btn_right, btn_mode, btn_pause, btn_speed;
    logic [10:0] POSX, pos_y;
    logic        frame_tick, hit_wall;

    int checks = 0;
    int errors = 0;

    // Frame-level model: 0 = bounce, 1 = manual, 2 = paused
    int m_x, m_y, m_vx, m_vy, m_speed, m_st, m_rs;

    sprite_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_mode   (btn_mode),
        .btn_pause  (btn_pause),
        .btn_speed  (btn_speed),
        .POSX       (POSX),
        .pos_y      (pos_y),
        .frame_tick (frame_tick),
        .hit_wall   (hit_wall)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 304; m_y = 232; m_vx = 1; m_vy = 1; m_speed = 1; m_st = 0; m_rs = 0;
    endtask

    task automatic press(input bit mode, input bit pause, input bit speed);
        @(posedge clk); #1;
        btn_mode = mode; btn_pause = pause; btn_speed = speed;
        repeat (4) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_pause = 1'b0; btn_speed = 1'b0;
        repeat (4) @(posedge clk);
        if (speed) m_speed = (m_speed == 7) ? 1 : m_speed + 1;
        if (mode) begin
            if (m_st == 0)      m_st = 1;
            else if (m_st == 1) m_st = 0;
            else                m_rs = 1 - m_rs;
        end
        if (pause) begin
            if (m_st == 2) m_st = m_rs;
            else begin m_rs = m_st; m_st = 2; end
        end
    endtask

    task automatic frame(input int hold, input bit left, input bit right);
        int ticks, hits, nx, ny, exp_hit;
        ticks = 0; hits = 0; exp_hit = 0;
        @(posedge clk); #1;
        btn_left = left; btn_right = right;
        repeat (3) @(posedge clk);
        #1;
        pix_x = 11'd0; pix_y = 11'd480;
        if (m_st == 0) begin
            nx = m_x + m_vx * m_speed;
            ny = m_y + m_vy * m_speed;
            if (nx < 0)         begin m_x = 0;    m_vx = 1;  exp_hit = 1; end
            else if (nx > XMAX) begin m_x = XMAX; m_vx = -1; exp_hit = 1; end
            else m_x = nx;
            if (ny < 0)         begin m_y = 0;    m_vy = 1;  exp_hit = 1; end
            else if (ny > YMAX) begin m_y = YMAX; m_vy = -1; exp_hit = 1; end
            else m_y = ny;
        end else if (m_st == 1) begin
            if (left && !right) begin
                nx = m_x - m_speed;
                if (nx < 0) begin nx = 0; exp_hit = 1; end
                m_x = nx;
            end else if (right && !left) begin
                nx = m_x + m_speed;
                if (nx > XMAX) begin nx = XMAX; exp_hit = 1; end
                m_x = nx;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            if (hit_wall) hits++;
            @(posedge clk); #1;
        end
        pix_x = 11'd5; pix_y = 11'd100;
        repeat (4) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            if (hit_wall) hits++;
        end
        check("tick_count", ticks, 1);
        check("hit_wall", hits, exp_hit);
        check("posx", POSX, m_x);
        check("pos_y", pos_y, m_y);
    endtask

    initial begin
        reset = 1'b1;
        pix_x = 11'd5; pix_y = 11'd100;
        btn_left = 1'b0; btn_right = 1'b0; btn_mode = 1'b0; btn_pause = 1'b0; btn_speed = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_posx", POSX, 304);
        check("rst_pos_y", pos_y, 232);
        check("rst_tick", frame_tick, 0);
        check("rst_hit", hit_wall, 0);
        reset = 1'b0;

        frame(4, 1'b0, 1'b0);

        // Sub-cycle glitch never straddles a clock edge and must not count.
        @(posedge clk); #2 btn_speed = 1'b1; #2 btn_speed = 1'b0;
        repeat (6) @(posedge clk);
        frame(2, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            press(1'b0, 1'b0, 1'b1);
            frame(1, 1'b0, 1'b0);
        end

        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) frame(3, 1'b1, 1'b0);
        frame(2, 1'b1, 1'b1);
        frame(2, 1'b0, 1'b1);

        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) frame(2, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b0);

        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 4)       press(1'b0, 1'b0, 1'b1);
            else if (r == 4) press(1'b1, 1'b0, 1'b0);
            else if (r == 5) press(1'b0, 1'b1, 1'b0);
            else if (r == 6) press(1'b1, 1'b1, 1'b0);
            else if (r == 7) press(1'b1, 1'b1, 1'b1);
            frame($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midrst_posx", POSX, 304);
        check("midrst_pos_y", pos_y, 232);
        model_reset();
        btn_left = 1'b0; btn_right = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        frame(3, 1'b0, 1'b0);
        frame(2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Upstream neighbour of the ROM sprite renderer. Produces the sprite's top-left position (POSX, pos_y), which the renderer compares against the scan position.
- Updates the position exactly once per video frame, at the start of vertical blanking, so a sprite is never torn mid-frame.
- Supports three modes: autonomous bounce inside the active area, manual left/right steering from buttons, and pause.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- SPRITE_W, 32, sprite width in pixels; must equal the renderer ROM column count.
- SPRITE_H, 16, sprite height in pixels; must equal the renderer ROM row count.
- X_INIT, 304, reset value of POSX.
- Y_INIT, 232, reset value of pos_y.
- MAX_SPEED, 7, maximum step in pixels per frame; legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_x  in  11  current scan column from the VGA timing generator.
- pix_y  in  11  current scan row from the VGA timing generator.
- btn_left  in  1  raw asynchronous button: steer left while held.
- btn_right  in  1  raw asynchronous button: steer right while held.
- btn_mode  in  1  raw asynchronous button: each press toggles between BOUNCE and MANUAL.
- btn_pause  in  1  raw asynchronous button: each press toggles pause.
- btn_speed  in  1  raw asynchronous button: each press cycles the speed.
- POSX  out  11  sprite left edge, registered.
- pos_y  out  11  sprite top edge, registered.
- frame_tick  out  1  one-cycle pulse marking the position update instant.
- hit_wall  out  1  one-cycle pulse, coincident with frame_tick, when a bounce or clamp occurred.

Behaviour:
- Reset (asynchronous, active-high) values:
  - POSX=X_INIT, pos_y=Y_INIT.
  - frame_tick=0, hit_wall=0.
  - state=BOUNCE, vx=+1, vy=+1 (direction signs), speed=1.
  - All synchronizer and edge-detect flops = 0.
- Button input path:
  - Each button passes through a 2-flop synchronizer.
  - btn_mode, btn_pause and btn_speed each get a rising-edge detector, producing a 1-cycle press pulse. Total latency from pin to pulse: 3 clk.
  - btn_left and btn_right are used as synchronized levels.
- Frame tick:
  - Condition: vb = (pix_x==0 && pix_y==V_ACTIVE).
  - vb is registered as vb_q; frame_tick = vb & ~vb_q.
  - Result: exactly one pulse per frame, even when the pixel clock is slower than clk and the scan position holds for several cycles.
- State machine:
  - States are BOUNCE, MANUAL, PAUSED; a separate register resume_state remembers the pre-pause mode.
  - Pause press in BOUNCE or MANUAL: store the current state in resume_state, go to PAUSED.
  - Pause press in PAUSED: return to resume_state.
  - Mode press in BOUNCE goes to MANUAL; in MANUAL goes to BOUNCE. Mode press in PAUSED flips resume_state only.
  - Simultaneous pause and mode presses: apply mode first, then pause.
  - State changes take effect on any clk; position changes only on frame_tick.
- Speed press: speed = (speed==MAX_SPEED) ? 1 : speed+1. Applies from the next frame_tick. Speed presses are honoured in all states.
- Position update (on frame_tick only):
  - Compute in 12-bit signed; nx = POSX ± speed, ny = pos_y ± speed.
  - X limits are 0 and XMAX = H_ACTIVE−SPRITE_W; Y limits are 0 and YMAX = V_ACTIVE−SPRITE_H.
  - BOUNCE:
    - If nx<0: POSX=0, vx=+1. If nx>XMAX: POSX=XMAX, vx=−1. Otherwise POSX=nx.
    - The same rule applies on Y with YMAX.
    - hit_wall=1 if either axis clamped; a corner hit gives one pulse.
  - MANUAL:
    - pos_y is held. btn_left only: POSX−speed, clamped at 0. btn_right only: POSX+speed, clamped at XMAX.
    - Both or neither held: POSX unchanged.
    - hit_wall=1 if a clamp occurred. vx and vy are unchanged.
  - PAUSED: POSX, pos_y, vx and vy all hold; hit_wall=0.
- No wrap-around: POSX is never greater than XMAX, and pos_y is never greater than YMAX.
- Output latency: POSX and pos_y change on the cycle after frame_tick is asserted, and are stable for the whole following active frame.
- Reset mid-frame: outputs return to reset values immediately. The first frame_tick after reset release updates from X_INIT/Y_INIT.

Decomposition:
- Shared package video_pkg:
  - H_ACTIVE, V_ACTIVE and COORD_W=11 constants.
  - motion_state_t enum {BOUNCE, MANUAL, PAUSED}.
- Sub-module btn_sync_edge:
  - Contains the 2-flop synchronizer plus rising-edge detector; outputs level and pulse.
  - Instantiated once per button (five instances).

Test Plan:
- Reset, then drive pix_y=480, pix_x=0 for 4 clk → exactly one frame_tick. Then POSX=305, pos_y=233, hit_wall=0.
- BOUNCE with POSX forced near 606, speed=3, vx=+1 → next tick POSX=608 (XMAX), vx=−1, hit_wall=1. Following tick POSX=605.
- Corner case: POSX=1, pos_y=1, vx=vy=−1, speed=2 → POSX=0, pos_y=0, exactly one hit_wall pulse, vx=vy=+1.
- Mode press, then hold btn_left, speed=1, POSX=2 → frames give 1, 0, 0. hit_wall only on the clamping frame; pos_y constant.
- Pause press → 5 ticks with POSX and pos_y unchanged. Mode press while paused, then pause press → resume in the flipped mode.
- Seven btn_speed presses starting from speed=1 → speed sequence 2..7 then 1. A 1-clk glitch shorter than the synchronizer window causes no double count.
